cell_refcnt_free: RTL and testbench

Reference-count tracker and free-request initiator for the shared packet cell memory. It records every cell granted by the cell allocator with a per-cell reader count, and it accepts per-reader release events. When a cell's count reaches zero, it queues the cell and issues a free request to one allocator free port over a valid/ready handshake. It sits between the output/reader side of the packet buffer and the allocator's free port, so multicast packets return to the free pool only after their last copy has been read.

---
 rtl/cell_refcnt_free.sv | 140 ++++++++++++++
 tb/tb_cell_refcnt_free.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_refcnt_free.sv
// rtl/cell_refcnt_free.sv - per-cell reader refcount tracker with in-order free-request queue
// A cell goes back to the allocator only after its last reader has released it.
module cell_refcnt_free #(
  parameter int LEN_WIDTH     = 16,
  parameter int CELL_NUM      = 64,
  parameter int CELL_ID_WIDTH = $clog2(CELL_NUM),
  parameter int REF_WIDTH     = 4,
  parameter int PEND_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_valid,
  input  logic [CELL_ID_WIDTH-1:0]     alloc_cell_id,
  input  logic [REF_WIDTH-1:0]         alloc_ref_cnt,
  input  logic [LEN_WIDTH-1:0]         alloc_mem_size,
  input  logic                         rel_valid,
  input  logic [CELL_ID_WIDTH-1:0]     rel_cell_id,
  output logic                         rel_ready,
  output logic                         free_mem_req,
  input  logic                         free_mem_ready,
  output logic [LEN_WIDTH-1:0]         free_mem_size,
  output logic [CELL_ID_WIDTH-1:0]     free_cell_id,
  output logic [CELL_ID_WIDTH:0]       live_cells,
  output logic [$clog2(PEND_DEPTH):0]  pend_count,
  output logic                         err_underflow,
  output logic                         err_collision
);

  localparam int PW = $clog2(PEND_DEPTH);
  localparam logic [REF_WIDTH-1:0]     REF_ONE   = {{(REF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]            PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]              PEND_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]              PEND_FULL = {1'b1, {PW{1'b0}}};
  localparam logic [CELL_ID_WIDTH:0]   LIVE_ONE  = {{CELL_ID_WIDTH{1'b0}}, 1'b1};

  logic [REF_WIDTH-1:0]     r_ref_cnt   [CELL_NUM];
  logic [LEN_WIDTH-1:0]     r_size      [CELL_NUM];
  logic [LEN_WIDTH-1:0]     r_fifo_size [PEND_DEPTH];
  logic [CELL_ID_WIDTH-1:0] r_fifo_id   [PEND_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [PW:0]              r_pend_count;
  logic [CELL_ID_WIDTH:0]   r_live_cells;
  logic                     r_err_underflow;
  logic                     r_err_collision;

  logic                     w_rel_fire;
  logic                     w_same_id;
  logic                     w_rel_eff;
  logic [REF_WIDTH-1:0]     w_rel_old;
  logic [REF_WIDTH-1:0]     w_alloc_old;
  logic [REF_WIDTH-1:0]     w_alloc_ref;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_live_inc;
  logic                     w_underflow;
  logic                     w_collision;

  assign rel_ready    = (r_pend_count < PEND_FULL);
  assign free_mem_req = (r_pend_count != '0);

  // Head fields read as zero while the queue is empty so reset values are clean.
  assign free_mem_size = free_mem_req ? r_fifo_size[r_rd_ptr] : '0;
  assign free_cell_id  = free_mem_req ? r_fifo_id[r_rd_ptr]   : '0;

  assign live_cells    = r_live_cells;
  assign pend_count    = r_pend_count;
  assign err_underflow = r_err_underflow;
  assign err_collision = r_err_collision;

  assign w_rel_fire  = rel_valid && rel_ready;
  assign w_rel_old   = r_ref_cnt[rel_cell_id];
  assign w_alloc_old = r_ref_cnt[alloc_cell_id];
  assign w_alloc_ref = (alloc_ref_cnt == '0) ? REF_ONE : alloc_ref_cnt;

  // A release colliding with an alloc of the same cell is swallowed; the alloc wins.
  assign w_same_id   = alloc_valid && w_rel_fire && (alloc_cell_id == rel_cell_id);
  assign w_rel_eff   = w_rel_fire && !w_same_id;

  assign w_push      = w_rel_eff && (w_rel_old == REF_ONE);
  assign w_pop       = free_mem_req && free_mem_ready;
  assign w_live_inc  = alloc_valid && (w_alloc_old == '0);
  assign w_underflow = w_rel_eff && (w_rel_old == '0);
  assign w_collision = alloc_valid && ((w_alloc_old != '0) || w_same_id);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELL_NUM; i++) begin
        r_ref_cnt[i] <= '0;
      end
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_pend_count    <= '0;
      r_live_cells    <= '0;
      r_err_underflow <= 1'b0;
      r_err_collision <= 1'b0;
    end else begin
      if (w_rel_eff && (w_rel_old != '0)) begin
        r_ref_cnt[rel_cell_id] <= w_rel_old - REF_ONE;
      end
      if (alloc_valid) begin
        r_ref_cnt[alloc_cell_id] <= w_alloc_ref;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_pend_count <= r_pend_count + PEND_ONE;
        2'b01:   r_pend_count <= r_pend_count - PEND_ONE;
        default: r_pend_count <= r_pend_count;
      endcase

      case ({w_live_inc, w_push})
        2'b10:   r_live_cells <= r_live_cells + LIVE_ONE;
        2'b01:   r_live_cells <= r_live_cells - LIVE_ONE;
        default: r_live_cells <= r_live_cells;
      endcase

      r_err_underflow <= w_underflow;
      r_err_collision <= w_collision;
    end
  end

  // Payload storage needs no reset: every read is qualified by a count or the queue occupancy.
  always_ff @(posedge clk) begin
    if (alloc_valid) begin
      r_size[alloc_cell_id] <= alloc_mem_size;
    end
    if (w_push) begin
      r_fifo_size[r_wr_ptr] <= r_size[rel_cell_id];
      r_fifo_id[r_wr_ptr]   <= rel_cell_id;
    end
  end

endmodule

// File: tb/tb_cell_refcnt_free.sv
// tb/tb_cell_refcnt_free.sv - self-checking bench for cell_refcnt_free
// Directed scenarios plus a randomized run against a queue/array reference model.
module tb_cell_refcnt_free;

  logic        clk;
  logic        rst_n;
  logic        alloc_valid;
  logic [5:0]  alloc_cell_id;
  logic [3:0]  alloc_ref_cnt;
  logic [15:0] alloc_mem_size;
  logic        rel_valid;
  logic [5:0]  rel_cell_id;
  logic        rel_ready;
  logic        free_mem_req;
  logic        free_mem_ready;
  logic [15:0] free_mem_size;
  logic [5:0]  free_cell_id;
  logic [6:0]  live_cells;
  logic [3:0]  pend_count;
  logic        err_underflow;
  logic        err_collision;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int sz;
    int id;
  } ent_t;

  int   m_cnt  [64];
  int   m_size [64];
  ent_t q [$];
  bit   e_uf;
  bit   e_col;

  cell_refcnt_free dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_valid   (alloc_valid),
    .alloc_cell_id (alloc_cell_id),
    .alloc_ref_cnt (alloc_ref_cnt),
    .alloc_mem_size(alloc_mem_size),
    .rel_valid     (rel_valid),
    .rel_cell_id   (rel_cell_id),
    .rel_ready     (rel_ready),
    .free_mem_req  (free_mem_req),
    .free_mem_ready(free_mem_ready),
    .free_mem_size (free_mem_size),
    .free_cell_id  (free_cell_id),
    .live_cells    (live_cells),
    .pend_count    (pend_count),
    .err_underflow (err_underflow),
    .err_collision (err_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_live();
    int n = 0;
    for (int i = 0; i < 64; i++) if (m_cnt[i] != 0) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    q.delete();
    e_uf = 0;
    e_col = 0;
  endtask

  // Applies one cycle of stimulus and advances the reference model across that edge.
  task automatic drive(input bit av, input int aid, input int aref, input int asz,
                       input bit rv, input int rid, input bit fr);
    bit   acc;
    bit   same;
    ent_t e;
    alloc_valid    = av;
    alloc_cell_id  = aid[5:0];
    alloc_ref_cnt  = aref[3:0];
    alloc_mem_size = asz[15:0];
    rel_valid      = rv;
    rel_cell_id    = rid[5:0];
    free_mem_ready = fr;
    acc   = rv && (q.size() < 8);
    same  = av && acc && (aid == rid);
    e_uf  = acc && !same && (m_cnt[rid] == 0);
    e_col = av && ((m_cnt[aid] != 0) || same);
    if (fr && q.size() > 0) e = q.pop_front();
    if (acc && !same && m_cnt[rid] > 0) begin
      if (m_cnt[rid] == 1) begin
        e.sz = m_size[rid];
        e.id = rid;
        q.push_back(e);
      end
      m_cnt[rid]--;
    end
    if (av) begin
      m_cnt[aid]  = (aref == 0) ? 1 : aref;
      m_size[aid] = asz;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit fr);
    drive(0, 0, 0, 0, 0, 0, fr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(0);
    n_checks++; if (free_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0d exp=0", free_mem_req); end
    n_checks++; if (pend_count !== 4'd0) begin n_fail++; $display("FAIL reset_pend got=%0d exp=0", pend_count); end
    n_checks++; if (live_cells !== 7'd0) begin n_fail++; $display("FAIL reset_live got=%0d exp=0", live_cells); end
    n_checks++; if (rel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rel_ready got=%0d exp=1", rel_ready); end
    n_checks++; if ({err_underflow, err_collision} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", {err_underflow, err_collision}); end
    n_checks++; if (free_mem_size !== 16'd0 || free_cell_id !== 6'd0) begin n_fail++; $display("FAIL reset_head got=%0d/%0d exp=0/0", free_mem_size, free_cell_id); end
  endtask

  task automatic test_unicast();
    drive(1, 5, 1, 1514, 0, 0, 0);
    n_checks++; if (live_cells !== 7'd1) begin n_fail++; $display("FAIL uni_live_alloc got=%0d exp=1", live_cells); end
    drive(0, 0, 0, 0, 1, 5, 0);
    n_checks++; if (free_mem_req !== 1'b1) begin n_fail++; $display("FAIL uni_req got=%0d exp=1", free_mem_req); end
    n_checks++; if (free_cell_id !== 6'd5) begin n_fail++; $display("FAIL uni_id got=%0d exp=5", free_cell_id); end
    n_checks++; if (free_mem_size !== 16'd1514) begin n_fail++; $display("FAIL uni_size got=%0d exp=1514", free_mem_size); end
    idle(1);
    n_checks++; if (pend_count !== 4'd0) begin n_fail++; $display("FAIL uni_pend got=%0d exp=0", pend_count); end
    n_checks++; if (live_cells !== 7'd0) begin n_fail++; $display("FAIL uni_live got=%0d exp=0", live_cells); end
    n_checks++; if (free_mem_req !== 1'b0) begin n_fail++; $display("FAIL uni_req_after got=%0d exp=0", free_mem_req); end
  endtask

  task automatic test_multicast();
    drive(1, 9, 3, 64, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 1, 9, 0);
      n_checks++; if (free_mem_req !== 1'b0) begin n_fail++; $display("FAIL mc_early_req%0d got=%0d exp=0", k, free_mem_req); end
    end
    drive(0, 0, 0, 0, 1, 9, 0);
    n_checks++; if (free_mem_req !== 1'b1 || free_cell_id !== 6'd9 || free_mem_size !== 16'd64) begin
      n_fail++; $display("FAIL mc_free got req=%0d id=%0d size=%0d exp req=1 id=9 size=64", free_mem_req, free_cell_id, free_mem_size);
    end
    n_checks++; if (pend_count !== 4'd1) begin n_fail++; $display("FAIL mc_pend got=%0d exp=1", pend_count); end
    idle(1);
  endtask

  task automatic test_backpressure();
    int ord[8] = '{13, 10, 17, 11, 16, 12, 15, 14};
    for (int i = 10; i < 18; i++) drive(1, i, 1, 200 + i, 0, 0, 0);
    drive(1, 20, 1, 999, 0, 0, 0);
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 1, ord[k], 0);
    n_checks++; if (pend_count !== 4'd8) begin n_fail++; $display("FAIL bp_pend_full got=%0d exp=8", pend_count); end
    n_checks++; if (rel_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rel_ready got=%0d exp=0", rel_ready); end
    drive(0, 0, 0, 0, 1, 20, 0);
    n_checks++; if (pend_count !== 4'd8) begin n_fail++; $display("FAIL bp_ninth_pend got=%0d exp=8", pend_count); end
    n_checks++; if (live_cells !== 7'd1) begin n_fail++; $display("FAIL bp_ninth_live got=%0d exp=1", live_cells); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (free_mem_req !== 1'b1 || free_cell_id !== ord[k][5:0] || free_mem_size !== 16'(200 + ord[k])) begin
        n_fail++; $display("FAIL bp_order%0d got req=%0d id=%0d size=%0d exp req=1 id=%0d size=%0d",
                           k, free_mem_req, free_cell_id, free_mem_size, ord[k], 200 + ord[k]);
      end
      idle(1);
      if (k == 0) begin
        n_checks++; if (rel_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rel_ready_back got=%0d exp=1", rel_ready); end
      end
    end
    n_checks++; if (pend_count !== 4'd0) begin n_fail++; $display("FAIL bp_drained got=%0d exp=0", pend_count); end
    drive(0, 0, 0, 0, 1, 20, 0);
    n_checks++; if (free_cell_id !== 6'd20 || free_mem_size !== 16'd999) begin
      n_fail++; $display("FAIL bp_id20 got id=%0d size=%0d exp id=20 size=999", free_cell_id, free_mem_size);
    end
    idle(1);
  endtask

  task automatic test_errors();
    drive(0, 0, 0, 0, 1, 3, 0);
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_pulse got=%0d exp=1", err_underflow); end
    n_checks++; if (pend_count !== 4'd0 || live_cells !== 7'd0) begin n_fail++; $display("FAIL uf_state got pend=%0d live=%0d exp 0/0", pend_count, live_cells); end
    idle(0);
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_one_cycle got=%0d exp=0", err_underflow); end
    drive(1, 7, 2, 300, 0, 0, 0);
    n_checks++; if (err_collision !== 1'b0) begin n_fail++; $display("FAIL col_first got=%0d exp=0", err_collision); end
    drive(1, 7, 2, 301, 0, 0, 0);
    n_checks++; if (err_collision !== 1'b1) begin n_fail++; $display("FAIL col_pulse got=%0d exp=1", err_collision); end
    n_checks++; if (live_cells !== 7'd1) begin n_fail++; $display("FAIL col_live got=%0d exp=1", live_cells); end
    drive(1, 7, 5, 302, 1, 7, 0);
    n_checks++; if (err_collision !== 1'b1) begin n_fail++; $display("FAIL col_same got=%0d exp=1", err_collision); end
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 1, 7, 0);
    n_checks++; if (free_mem_req !== 1'b0 || err_collision !== 1'b0) begin
      n_fail++; $display("FAIL col_count_early got req=%0d col=%0d exp 0/0", free_mem_req, err_collision);
    end
    drive(0, 0, 0, 0, 1, 7, 0);
    n_checks++; if (free_mem_req !== 1'b1 || free_mem_size !== 16'd302) begin
      n_fail++; $display("FAIL col_count_final got req=%0d size=%0d exp req=1 size=302", free_mem_req, free_mem_size);
    end
    idle(1);
  endtask

  task automatic test_ref0_and_reset();
    drive(1, 2, 0, 100, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 2, 0);
    n_checks++; if (free_mem_req !== 1'b1 || free_cell_id !== 6'd2) begin
      n_fail++; $display("FAIL ref0 got req=%0d id=%0d exp req=1 id=2", free_mem_req, free_cell_id);
    end
    idle(1);
    for (int i = 30; i < 34; i++) drive(1, i, 1, i, 0, 0, 0);
    drive(1, 40, 2, 1, 0, 0, 0);
    for (int i = 30; i < 34; i++) drive(0, 0, 0, 0, 1, i, 0);
    n_checks++; if (pend_count !== 4'd4 || live_cells !== 7'd1) begin
      n_fail++; $display("FAIL rst_pre got pend=%0d live=%0d exp 4/1", pend_count, live_cells);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (free_mem_req !== 1'b0 || pend_count !== 4'd0 || live_cells !== 7'd0) begin
      n_fail++; $display("FAIL rst_async got req=%0d pend=%0d live=%0d exp 0/0/0", free_mem_req, pend_count, live_cells);
    end
    model_clear();
    drive(1, 50, 1, 5, 1, 50, 1);
    model_clear();
    rst_n = 1'b1;
    idle(0);
    n_checks++; if (live_cells !== 7'd0 || pend_count !== 4'd0) begin
      n_fail++; $display("FAIL rst_ignored got live=%0d pend=%0d exp 0/0", live_cells, pend_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit av, rv, fr;
      int aid, rid, aref, asz;
      av   = ($urandom_range(0, 2) == 0);
      rv   = ($urandom_range(0, 1) == 0);
      fr   = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      aid  = $urandom_range(0, 11);
      rid  = $urandom_range(0, 11);
      aref = $urandom_range(0, 3);
      asz  = $urandom_range(0, 65535);
      n_checks++; if (rel_ready !== (q.size() < 8)) begin n_fail++; $display("FAIL rnd_rel_ready c=%0d got=%0d exp=%0d", c, rel_ready, q.size() < 8); end
      n_checks++; if (free_mem_req !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_req c=%0d got=%0d exp=%0d", c, free_mem_req, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++; if (free_cell_id !== q[0].id[5:0] || free_mem_size !== q[0].sz[15:0]) begin
          n_fail++; $display("FAIL rnd_head c=%0d got id=%0d size=%0d exp id=%0d size=%0d", c, free_cell_id, free_mem_size, q[0].id, q[0].sz);
        end
      end
      drive(av, aid, aref, asz, rv, rid, fr);
      n_checks++; if (err_underflow !== e_uf) begin n_fail++; $display("FAIL rnd_uf c=%0d got=%0d exp=%0d", c, err_underflow, e_uf); end
      n_checks++; if (err_collision !== e_col) begin n_fail++; $display("FAIL rnd_col c=%0d got=%0d exp=%0d", c, err_collision, e_col); end
      n_checks++; if (live_cells !== 7'(m_live())) begin n_fail++; $display("FAIL rnd_live c=%0d got=%0d exp=%0d", c, live_cells, m_live()); end
      n_checks++; if (pend_count !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_pend c=%0d got=%0d exp=%0d", c, pend_count, q.size()); end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    alloc_valid    = 1'b0;
    alloc_cell_id  = '0;
    alloc_ref_cnt  = '0;
    alloc_mem_size = '0;
    rel_valid      = 1'b0;
    rel_cell_id    = '0;
    free_mem_ready = 1'b0;
    #1;
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_errors();
    test_ref0_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
